cipher_msg_sequencer: RTL and testbench
=======================================

CIPHER_MSG_SEQUENCER -- requirements
Module: cipher_msg_sequencer

Interface
REQ-001 SHALL have parameter MSG_LEN, default 12, bytes per message block.
REQ-002 SHALL have parameter CORE_LAT, default 1, cycles from core_start to valid core_dout; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock. All logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports in_valid, input, 1, and in_ready, output, 1, the input byte handshake.
REQ-006 SHALL have port in_data, input, 8, plaintext or ciphertext byte.
REQ-007 SHALL have port in_mode, input, 1, selecting 0 = encrypt or 1 = decrypt; sampled on the first byte of a message.
REQ-008 SHALL have ports out_valid, output, 1, and out_ready, input, 1, the output byte handshake.
REQ-009 SHALL have ports out_data, output, 8, and out_last, output, 1; out_last marks the final byte of a block.
REQ-010 SHALL have port core_din, output, 8*MSG_LEN, the buffered block; byte i sits at bits [8i+7:8i].
REQ-011 SHALL have port core_mode, output, 1, the latched mode driven to the core.
REQ-012 SHALL have port core_start, output, 1, a one-cycle pulse.
REQ-013 SHALL have port core_dout, input, 8*MSG_LEN, the core result with the same byte ordering.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement four states: IDLE, LOAD, WAIT, DRAIN.
REQ-016 IDLE: in_ready=1. An accepted byte is stored at index 0, in_mode is latched, and the state goes to LOAD, or to WAIT directly if MSG_LEN=1.
REQ-017 LOAD: in_ready=1. Each accepted byte is stored at the byte counter index. Accepting byte MSG_LEN-1 moves the state to WAIT and pulses core_start on the next cycle.
REQ-018 WAIT: in_ready=0. A latency counter counts CORE_LAT cycles after core_start. core_dout is then captured into the result buffer and the state goes to DRAIN.
REQ-019 DRAIN: out_valid=1, presenting bytes 0..MSG_LEN-1 in order. The index advances only when out_valid && out_ready. out_last=1 on index MSG_LEN-1. The handshake on the last byte returns the state to IDLE.
REQ-020 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-021 SHALL make in_ready=0 in WAIT and DRAIN; in_valid is ignored there, with no buffering and no error.
REQ-022 SHALL classify each byte as special if it is outside 0x41..0x5A and outside 0x61..0x7A. Boundaries 0x40, 0x5B, 0x60 and 0x7B are special.
REQ-023 core_din SHALL hold the complete buffer from core_start until capture. Unfilled bytes are never exposed, because core_start fires only on a full block.
REQ-024 Latency: last input handshake at edge t, core_start high in cycle t+1, capture at edge t+1+CORE_LAT, first out_valid in cycle t+2+CORE_LAT.
REQ-025 SHALL wrap the byte counters to 0 at block end; no partial-block flush exists.

Reset
REQ-026 rst SHALL force state IDLE, counters to 0, and the following outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, core_start=0, core_mode=0, busy=0.
REQ-027 Reset during LOAD, WAIT or DRAIN SHALL discard the buffered block. A core result arriving later SHALL be ignored.

Configuration
REQ-028 Macro CIPHER_SPECIAL_BYPASS_EN defined: a per-byte special flag is captured at input. For flagged bytes, out_data equals the original input byte instead of core_dout.
REQ-029 Macro CIPHER_SPECIAL_BYPASS_EN undefined: the flag register is absent and out_data is always the captured core_dout byte.

Structure
REQ-030 Package cipher_seq_pkg SHALL hold the state enum and the ASCII bound constants (0x41, 0x5A, 0x61, 0x7A).
REQ-031 Sub-module cipher_char_class SHALL be combinational and take a byte in and produce is_special out; it is shared with the bench.

Verification
REQ-032 The bench core stub SHALL be core_dout = core_din XOR 0x01 per byte, with CORE_LAT=1.
REQ-033 Letters test: in_mode=0, "HELLOWORLDAB" -> output "IDMMNVNSME@C", out_last on byte 12, first out_valid 3 cycles after the last input handshake.
REQ-034 All-special test: "~ !@#$%^&*()" with the macro defined -> output identical to input. With the macro undefined -> output is each byte XOR 0x01 ("\x7F!\x20A\x22%\x24_'+)(").
REQ-035 Boundary test: "@AZ[`az{0909" with the macro defined -> output "@@[[`\x60{{0909"; here A->@, Z->[, a->`, z->{ and the specials are unchanged.
REQ-036 Backpressure test: out_ready low for 3 cycles at byte index 5 -> out_data stable, all 12 bytes delivered once in order, in_ready=0 throughout.
REQ-037 Reset test: rst for 1 cycle after 5 bytes in LOAD -> next cycle state IDLE with in_ready=1 and out_valid=0. A following full block then processes correctly with no stale bytes.

Source files
------------

// File: rtl/cipher_seq_pkg.sv
// cipher_seq_pkg
// Shared definitions for the cipher message sequencer:
//   - seq_state_t    : sequencer FSM state encoding
//   - ASCII_*        : inclusive bounds of the upper- and lower-case letter ranges
package cipher_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_t;

  localparam logic [7:0] ASCII_UPPER_LO = 8'h41;  // 'A'
  localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;  // 'Z'
  localparam logic [7:0] ASCII_LOWER_LO = 8'h61;  // 'a'
  localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;  // 'z'

endpackage

// File: rtl/cipher_char_class.sv
// cipher_char_class
// Combinational byte classifier. A byte is "special" when it is neither an
// upper-case nor a lower-case ASCII letter.
// Ports:
//   char_byte  (in,  8) byte to classify
//   is_special (out, 1) 1 when char_byte lies outside 'A'..'Z' and 'a'..'z'
module cipher_char_class
  import cipher_seq_pkg::*;
(
  input  logic [7:0] char_byte,
  output logic       is_special
);

  logic is_upper;
  logic is_lower;

  assign is_upper   = (char_byte >= ASCII_UPPER_LO) && (char_byte <= ASCII_UPPER_HI);
  assign is_lower   = (char_byte >= ASCII_LOWER_LO) && (char_byte <= ASCII_LOWER_HI);
  assign is_special = !(is_upper || is_lower);

endmodule

// File: rtl/cipher_msg_sequencer.sv
// cipher_msg_sequencer
// Collects MSG_LEN input bytes into a block, hands the block to a cipher core
// with a one-cycle core_start pulse, waits CORE_LAT cycles, captures the core
// result and streams it out byte by byte.
// Parameters: MSG_LEN (bytes per block), CORE_LAT (core latency, 1..15).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_mode input byte stream; mode taken on byte 0
//   out_valid/out_ready/out_data/out_last output byte stream, last = block end
//   core_din/core_mode/core_start     block, mode and start pulse to the core
//   core_dout                         core result, byte i at bits [8i+7:8i]
//   busy                              high whenever not idle
// Build option: define CIPHER_SPECIAL_BYPASS_EN to pass non-letter bytes
// through unchanged instead of using the core result for them.
module cipher_msg_sequencer
  import cipher_seq_pkg::*;
#(
  parameter int MSG_LEN  = 12,
  parameter int CORE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_last,
  output logic [8*MSG_LEN-1:0] core_din,
  output logic                 core_mode,
  output logic                 core_start,
  input  logic [8*MSG_LEN-1:0] core_dout,
  output logic                 busy
);

  localparam int               CNT_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_LEN - 1);
  localparam logic [3:0]       LAT_END  = 4'(CORE_LAT);

  seq_state_t       state_reg, state_next;
  logic [CNT_W-1:0] in_cnt_reg, out_cnt_reg;
  logic [3:0]       lat_cnt_reg;
  logic [7:0]       in_buf_reg  [MSG_LEN];
  logic [7:0]       res_buf_reg [MSG_LEN];
  logic             mode_reg;
  logic             start_reg;
  logic [7:0]       drain_byte;

  logic in_accept, in_last, lat_done, out_accept, out_done;

  assign in_accept  = in_valid && in_ready;
  assign in_last    = (in_cnt_reg == LAST_IDX);
  assign lat_done   = (state_reg == ST_WAIT) && (lat_cnt_reg == LAT_END);
  assign out_accept = out_valid && out_ready;
  assign out_done   = out_accept && (out_cnt_reg == LAST_IDX);

  assign core_mode  = mode_reg;
  assign core_start = start_reg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; a single-byte block goes straight from IDLE to WAIT
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (in_accept) state_next = in_last ? ST_WAIT : ST_LOAD;
      ST_LOAD:  if (in_accept && in_last) state_next = ST_WAIT;
      ST_WAIT:  if (lat_done) state_next = ST_DRAIN;
      ST_DRAIN: if (out_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs; out_data is forced to zero outside DRAIN so nothing stale leaks
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'h00;
    busy      = (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE, ST_LOAD: in_ready = 1'b1;
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (out_cnt_reg == LAST_IDX);
        out_data  = drain_byte;
      end
      default: ;
    endcase
  end

  // Input side: byte buffer, mode latch, start pulse, latency and output counters.
  // The latency counter is cleared with the start pulse and counts edges in WAIT,
  // so capture lands CORE_LAT edges after the edge that ends the start cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_reg  <= '0;
      out_cnt_reg <= '0;
      lat_cnt_reg <= '0;
      mode_reg    <= 1'b0;
      start_reg   <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) in_buf_reg[i] <= 8'h00;
    end else begin
      start_reg <= 1'b0;
      if (in_accept) begin
        in_buf_reg[in_cnt_reg] <= in_data;
        if (state_reg == ST_IDLE) mode_reg <= in_mode;
        if (in_last) begin
          in_cnt_reg  <= '0;
          start_reg   <= 1'b1;
          lat_cnt_reg <= '0;
        end else begin
          in_cnt_reg <= in_cnt_reg + 1'b1;
        end
      end
      if ((state_reg == ST_WAIT) && !lat_done) lat_cnt_reg <= lat_cnt_reg + 1'b1;
      if (out_accept) out_cnt_reg <= out_done ? '0 : out_cnt_reg + 1'b1;
    end
  end

  // Per-byte block exposure and result capture. The result buffer needs no
  // reset: it is only observed in DRAIN, which is entered only after a capture.
  generate
    for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_byte
      assign core_din[8*gi +: 8] = in_buf_reg[gi];
      always_ff @(posedge clk) begin
        if (lat_done) res_buf_reg[gi] <= core_dout[8*gi +: 8];
      end
    end
  endgenerate

`ifdef CIPHER_SPECIAL_BYPASS_EN
  logic in_special;
  logic special_reg [MSG_LEN];

  cipher_char_class u_char_class (
    .char_byte  (in_data),
    .is_special (in_special)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) special_reg[i] <= 1'b0;
    end else if (in_accept) begin
      special_reg[in_cnt_reg] <= in_special;
    end
  end

  // The input buffer is not reloaded until DRAIN ends, so the original byte is still there
  assign drain_byte = special_reg[out_cnt_reg] ? in_buf_reg[out_cnt_reg]
                                               : res_buf_reg[out_cnt_reg];
`else
  assign drain_byte = res_buf_reg[out_cnt_reg];
`endif

endmodule

// File: tb/tb_cipher_msg_sequencer.sv
// tb_cipher_msg_sequencer
// Directed bench for cipher_msg_sequencer with a registered core stub that
// returns core_din XOR 0x01 per byte one cycle after core_start.
// Expected outputs follow the CIPHER_SPECIAL_BYPASS_EN build setting.
module tb_cipher_msg_sequencer;

  localparam int MSG_LEN  = 12;
  localparam int CORE_LAT = 1;

  localparam logic [95:0] LET_IN      = "HELLOWORLDAB";
  localparam logic [95:0] LET_OUT     = "IDMMNVNSME@C";
  localparam logic [95:0] SPC_IN      = 96'h7E2021402324255E262A2829;
  localparam logic [95:0] BND_IN      = 96'h40415A5B60617A7B30393039;
`ifdef CIPHER_SPECIAL_BYPASS_EN
  localparam logic [95:0] SPC_OUT     = 96'h7E2021402324255E262A2829;
  localparam logic [95:0] BND_OUT     = 96'h40405B5B60607B7B30393039;
`else
  localparam logic [95:0] SPC_OUT     = 96'h7F2120412225245F272B2928;
  localparam logic [95:0] BND_OUT     = 96'h41405B5A61607B7A31383138;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [7:0]           in_data = 8'h00;
  logic                 in_mode = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [7:0]           out_data;
  logic                 out_last;
  logic [8*MSG_LEN-1:0] core_din;
  logic                 core_mode;
  logic                 core_start;
  logic [8*MSG_LEN-1:0] core_dout = '0;
  logic                 busy;

  logic [7:0] cls_in = 8'h00;
  logic       cls_special;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stub
  always @(posedge clk) begin
    if (core_start) core_dout <= core_din ^ {MSG_LEN{8'h01}};
  end

  cipher_msg_sequencer #(.MSG_LEN(MSG_LEN), .CORE_LAT(CORE_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .core_din   (core_din),
    .core_mode  (core_mode),
    .core_start (core_start),
    .core_dout  (core_dout),
    .busy       (busy)
  );

  cipher_char_class u_cls (
    .char_byte  (cls_in),
    .is_special (cls_special)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte i of a string-style vector (first character in the MSBs)
  function automatic logic [7:0] byte_at(input logic [95:0] v, input int i);
    return v[8*(MSG_LEN-1-i) +: 8];
  endfunction

  // Feed one full block; returns the cycle stamp of the last handshake edge.
  // in_mode is inverted after byte 0 to show it is only sampled on the first byte.
  task automatic send_block(input string name, input logic [95:0] v, input logic mode,
                            output int t_last);
    logic [95:0] exp_din;
    for (int i = 0; i < MSG_LEN; i++) begin
      @(negedge clk);
      if (i == 0) check($sformatf("%s_rdy_idle", name), in_ready, 1);
      in_valid = 1'b1;
      in_data  = byte_at(v, i);
      in_mode  = (i == 0) ? mode : ~mode;
      exp_din[8*i +: 8] = byte_at(v, i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    t_last   = cyc;
    check($sformatf("%s_start", name), core_start, 1);
    check($sformatf("%s_mode", name), core_mode, mode);
    check($sformatf("%s_rdy_wait", name), in_ready, 0);
    check($sformatf("%s_busy", name), busy, 1);
    check($sformatf("%s_din_lo", name), core_din[31:0], exp_din[31:0]);
    check($sformatf("%s_din_hi", name), core_din[95:64], exp_din[95:64]);
  endtask

  // Drain one block and compare every byte; optional stall and junk input
  task automatic recv_block(input string name, input logic [95:0] exp, input int t_last,
                            input int stall_idx, input int stall_len, input logic junk);
    int idx     = 0;
    int stalled = 0;
    int waited  = 0;
    bit first   = 1'b1;
    while (idx < MSG_LEN && waited < 200) begin
      @(negedge clk);
      waited++;
      if (waited == 1) check($sformatf("%s_pulse", name), core_start, 0);
      if (junk) begin
        in_valid = 1'b1;
        in_data  = 8'hAA;
      end
      if (!out_valid) begin
        out_ready = 1'b1;
        continue;
      end
      if (first) begin
        check($sformatf("%s_latency", name), cyc - t_last, CORE_LAT + 1);
        first = 1'b0;
      end
      if (idx == stall_idx && stalled < stall_len) begin
        out_ready = 1'b0;
        check($sformatf("%s_hold%0d", name, stalled), out_data, byte_at(exp, idx));
        check($sformatf("%s_hold_last%0d", name, stalled), out_last, 0);
        check($sformatf("%s_hold_rdy%0d", name, stalled), in_ready, 0);
        stalled++;
      end else begin
        out_ready = 1'b1;
        check($sformatf("%s_b%0d", name, idx), out_data, byte_at(exp, idx));
        check($sformatf("%s_last%0d", name, idx), out_last, (idx == MSG_LEN - 1) ? 1 : 0);
        if (junk) check($sformatf("%s_rdy_drain%0d", name, idx), in_ready, 0);
        if (idx == MSG_LEN - 1) in_valid = 1'b0;
        idx++;
      end
    end
    if (idx < MSG_LEN) check($sformatf("%s_timeout", name), idx, MSG_LEN);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("%s_idle_valid", name), out_valid, 0);
    check($sformatf("%s_idle_busy", name), busy, 0);
    $display("block %s: %0d bytes drained, checks so far %0d", name, idx, checks);
  endtask

  logic [8:0] cls_tab [10] = '{
    {1'b1, 8'h40}, {1'b0, 8'h41}, {1'b0, 8'h5A}, {1'b1, 8'h5B}, {1'b1, 8'h60},
    {1'b0, 8'h61}, {1'b0, 8'h7A}, {1'b1, 8'h7B}, {1'b1, 8'h30}, {1'b1, 8'hFF}
  };

  initial begin
    int  t;
    bit  stray;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_mode", core_mode, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Classifier boundaries
    for (int i = 0; i < 10; i++) begin
      cls_in = cls_tab[i][7:0];
      #1;
      check($sformatf("class_%0h", cls_tab[i][7:0]), cls_special, cls_tab[i][8]);
    end

    send_block("letters", LET_IN, 1'b0, t);
    recv_block("letters", LET_OUT, t, -1, 0, 1'b0);

    send_block("special", SPC_IN, 1'b1, t);
    recv_block("special", SPC_OUT, t, -1, 0, 1'b0);

    send_block("bound", BND_IN, 1'b0, t);
    recv_block("bound", BND_OUT, t, -1, 0, 1'b0);

    send_block("bpress", LET_IN, 1'b1, t);
    recv_block("bpress", LET_OUT, t, 5, 3, 1'b1);

    // Reset after 5 bytes in LOAD
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = byte_at(SPC_IN, i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("load_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("load_rst_in_ready", in_ready, 1);
    check("load_rst_out_valid", out_valid, 0);
    check("load_rst_busy", busy, 0);
    send_block("after_load_rst", BND_IN, 1'b0, t);
    recv_block("after_load_rst", BND_OUT, t, -1, 0, 1'b0);

    // Reset while the core is working; its late result must be ignored
    send_block("wait_rst", LET_IN, 1'b0, t);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid || busy) stray = 1'b1;
    end
    check("wait_rst_quiet", stray, 0);
    send_block("after_wait_rst", SPC_IN, 1'b1, t);
    recv_block("after_wait_rst", SPC_OUT, t, -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
